// File: rtl/framebuffer_fetch_pkg.sv
// Shared types and constants for the framebuffer pixel fetcher.
package framebuffer_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int RAM_LATENCY_MIN = 1;
  localparam int RAM_LATENCY_MAX = 4;

  // Channel field width; never narrower than one bit so the field always exists.
  function automatic int ch_bits(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_fetch_multi_ram_read_pipe.sv
// Valid/channel delay line that matches the RAM read latency; its tail marks
// the cycle in which ram_data_in belongs to the tagged channel.
module ram_read_pipe #(
  parameter int CH_BITS = 1,
  parameter int LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               push,
  input  logic [CH_BITS-1:0] push_ch,
  output logic               capture,
  output logic [CH_BITS-1:0] capture_ch
);

  logic [LATENCY-1:0] valid_q;
  logic [CH_BITS-1:0] ch_q [LATENCY];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) ch_q[i] <= '0;
    end else begin
      valid_q[0] <= push;
      ch_q[0]    <= push_ch;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        ch_q[i]    <= ch_q[i-1];
      end
    end
  end

  assign capture    = valid_q[LATENCY-1];
  assign capture_ch = ch_q[LATENCY-1];

endmodule

// File: rtl/framebuffer_fetch_multi.sv
// Multi-channel pixel fetcher: one RAM read per scan channel per load request.
// Define FRAMEBUFFER_FETCH_FRAME_SELECT_EN to add a frame_select address MSB.
//
// state    | meaning
// ST_IDLE  | waiting for pixel_load_start, RAM clock gated
// ST_ISSUE | presenting one channel address per cycle
// ST_DRAIN | waiting for the last channel's read data
module framebuffer_fetch_multi
  import framebuffer_fetch_pkg::*;
#(
  parameter int PIXEL_WIDTH   = 16,
  parameter int COLUMN_BITS   = 6,
  parameter int ROW_BITS      = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int RAM_LATENCY   = 2,
  parameter int COLUMN_MIRROR = 1,
  localparam int CH_BITS      = ch_bits(NUM_CHANNELS),
`ifdef FRAMEBUFFER_FETCH_FRAME_SELECT_EN
  localparam int FRAME_BITS   = 1,
`else
  localparam int FRAME_BITS   = 0,
`endif
  localparam int ADDR_WIDTH   = FRAME_BITS + CH_BITS + ROW_BITS + COLUMN_BITS
) (
  input  logic                                clk_in,
  input  logic                                reset_n,
  input  logic [COLUMN_BITS-1:0]              column_address,
  input  logic [ROW_BITS-1:0]                 row_address,
  input  logic                                pixel_load_start,
  output logic                                busy,
  output logic                                pixel_load_done,
`ifdef FRAMEBUFFER_FETCH_FRAME_SELECT_EN
  input  logic                                frame_select,
`endif
  input  logic [PIXEL_WIDTH-1:0]              ram_data_in,
  output logic [ADDR_WIDTH-1:0]               ram_address,
  output logic                                ram_clk_enable,
  output logic                                ram_reset,
  output logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] pixels_out
);

  if (NUM_CHANNELS < 2 || (NUM_CHANNELS & (NUM_CHANNELS - 1)) != 0) begin : g_bad_channels
    $error("NUM_CHANNELS must be a power of two and at least 2");
  end
  if (RAM_LATENCY < RAM_LATENCY_MIN || RAM_LATENCY > RAM_LATENCY_MAX) begin : g_bad_latency
    $error("RAM_LATENCY out of range");
  end

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CHANNELS - 1);

  fetch_state_e state_q, state_d;
  logic accept, issue, finish, capture;
  logic [CH_BITS-1:0]     ch_q, cap_ch, addr_ch;
  logic [ROW_BITS-1:0]    row_q, addr_row;
  logic [COLUMN_BITS-1:0] col_q, addr_col;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [PIXEL_WIDTH-1:0] staging [NUM_CHANNELS];
  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] merged;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pixel_load_start) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (ch_q == LAST_CH) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (capture && cap_ch == LAST_CH) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Column is stored already mirrored so every issued address reuses it as-is.
  always_comb begin
    if (accept) begin
      addr_ch  = '0;
      addr_row = row_address;
      addr_col = (COLUMN_MIRROR != 0) ? ~column_address : column_address;
    end else begin
      addr_ch  = ch_q + CH_BITS'(1);
      addr_row = row_q;
      addr_col = col_q;
    end
  end

`ifdef FRAMEBUFFER_FETCH_FRAME_SELECT_EN
  logic frame_q, addr_frame;
  assign addr_frame = accept ? frame_select : frame_q;
  assign addr_next  = {addr_frame, addr_ch, addr_row, addr_col};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)    frame_q <= 1'b0;
    else if (accept) frame_q <= frame_select;
  end
`else
  assign addr_next = {addr_ch, addr_row, addr_col};
`endif

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      ch_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ram_address <= '0;
    end else if (accept || (issue && ch_q != LAST_CH)) begin
      ch_q        <= addr_ch;
      row_q       <= addr_row;
      col_q       <= addr_col;
      ram_address <= addr_next;
    end
  end

  ram_read_pipe #(
    .CH_BITS (CH_BITS),
    .LATENCY (RAM_LATENCY)
  ) u_pipe (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .push       (issue),
    .push_ch    (ch_q),
    .capture    (capture),
    .capture_ch (cap_ch)
  );

  // The final channel's data is merged in on the way to pixels_out so the
  // visible word changes exactly once per load.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      merged[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
        (capture && cap_ch == CH_BITS'(i)) ? ram_data_in : staging[i];
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) staging[i] <= '0;
      pixels_out      <= '0;
      pixel_load_done <= 1'b0;
    end else begin
      if (capture) staging[cap_ch] <= ram_data_in;
      if (finish)  pixels_out <= merged;
      pixel_load_done <= finish;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign ram_clk_enable = (state_q != ST_IDLE);
  assign ram_reset      = ~reset_n;

endmodule

// File: tb/tb_framebuffer_fetch_multi.sv
// Bench for framebuffer_fetch_multi: default instance (2 ch, latency 2, mirrored)
// and a 4 ch / latency 3 / unmirrored instance, each fed by a RAM that returns its address.
module tb_framebuffer_fetch_multi;

`ifdef FRAMEBUFFER_FETCH_FRAME_SELECT_EN
  localparam int FSB = 1;
`else
  localparam int FSB = 0;
`endif
  localparam int AW_A = FSB + 1 + 4 + 6;
  localparam int AW_B = FSB + 2 + 4 + 6;
  localparam int LA = 2;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] col_a = '0, col_b = '0;
  logic [3:0] row_a = '0, row_b = '0;
  logic start_a = 1'b0, start_b = 1'b0, fs_a = 1'b0, fs_b = 1'b0;
  logic busy_a, done_a, clken_a, rreset_a, busy_b, done_b, clken_b, rreset_b;
  logic [15:0] rdata_a, rdata_b;
  logic [AW_A-1:0] addr_a;
  logic [AW_B-1:0] addr_b;
  logic [31:0] pix_a;
  logic [63:0] pix_b;

  framebuffer_fetch_multi dut_a (
    .clk_in(clk), .reset_n(reset_n), .column_address(col_a), .row_address(row_a),
    .pixel_load_start(start_a), .busy(busy_a), .pixel_load_done(done_a),
`ifdef FRAMEBUFFER_FETCH_FRAME_SELECT_EN
    .frame_select(fs_a),
`endif
    .ram_data_in(rdata_a), .ram_address(addr_a), .ram_clk_enable(clken_a),
    .ram_reset(rreset_a), .pixels_out(pix_a)
  );

  framebuffer_fetch_multi #(.NUM_CHANNELS(4), .RAM_LATENCY(3), .COLUMN_MIRROR(0)) dut_b (
    .clk_in(clk), .reset_n(reset_n), .column_address(col_b), .row_address(row_b),
    .pixel_load_start(start_b), .busy(busy_b), .pixel_load_done(done_b),
`ifdef FRAMEBUFFER_FETCH_FRAME_SELECT_EN
    .frame_select(fs_b),
`endif
    .ram_data_in(rdata_b), .ram_address(addr_b), .ram_clk_enable(clken_b),
    .ram_reset(rreset_b), .pixels_out(pix_b)
  );

  // RAM models: data = address presented LA / LB edges earlier.
  logic [AW_A-1:0] hist_a [LA];
  logic [AW_B-1:0] hist_b [LB];
  always @(posedge clk) begin
    hist_a[0] <= addr_a;
    for (int i = 1; i < LA; i++) hist_a[i] <= hist_a[i-1];
    hist_b[0] <= addr_b;
    for (int i = 1; i < LB; i++) hist_b[i] <= hist_b[i-1];
  end
  assign rdata_a = 16'(hist_a[LA-1]);
  assign rdata_b = 16'(hist_b[LB-1]);

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: address/pixel words from the addressing rules.
  function automatic int nch(input int which);
    return (which == 0) ? 2 : 4;
  endfunction
  function automatic int lat(input int which);
    return (which == 0) ? 2 + LA : 4 + LB;
  endfunction
  function automatic logic [63:0] exp_addr(input int which, input int ch, input int row,
                                           input int col, input int fs);
    int c, cb;
    c  = (which == 0) ? (63 - col) : col;
    cb = (which == 0) ? 1 : 2;
    exp_addr = 64'(c + row * 64 + ch * 1024);
`ifdef FRAMEBUFFER_FETCH_FRAME_SELECT_EN
    exp_addr = exp_addr + (64'(fs) << (10 + cb));
`else
    if (fs > 1 || cb > 2) exp_addr = '0;
`endif
  endfunction
  function automatic logic [63:0] exp_pix(input int which, input int row, input int col, input int fs);
    exp_pix = '0;
    for (int ch = 0; ch < nch(which); ch++)
      exp_pix = exp_pix | ((exp_addr(which, ch, row, col, fs) & 64'hFFFF) << (16 * ch));
  endfunction

  function automatic logic [63:0] get_addr(input int which);
    return (which == 0) ? 64'(addr_a) : 64'(addr_b);
  endfunction
  function automatic logic [63:0] get_pix(input int which);
    return (which == 0) ? 64'(pix_a) : pix_b;
  endfunction
  function automatic logic get_done(input int which);
    return (which == 0) ? done_a : done_b;
  endfunction
  function automatic logic get_busy(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_clken(input int which);
    return (which == 0) ? clken_a : clken_b;
  endfunction

  task automatic set_in(input int which, input int row, input int col, input int fs, input logic st);
    if (which == 0) begin
      row_a = 4'(row); col_a = 6'(col); fs_a = fs[0]; start_a = st;
    end else begin
      row_b = 4'(row); col_b = 6'(col); fs_b = fs[0]; start_b = st;
    end
  endtask
  task automatic set_start(input int which, input logic st);
    if (which == 0) start_a = st;
    else            start_b = st;
  endtask

  // One load; inputs are scrambled while busy and optionally start is poked mid-load.
  task automatic run_load(input int which, input int row, input int col, input int fs, input bit poke);
    int e = 0;
    bit got = 0, partial_ok = 1;
    logic [63:0] prev;
    prev = get_pix(which);
    @(negedge clk);
    set_in(which, row, col, fs, 1'b1);
    @(posedge clk); #1;
    set_in(which, (row + 7) % 16, (col + 29) % 64, 1 - fs, 1'b0);
    check("addr_ch0", get_addr(which), exp_addr(which, 0, row, col, fs));
    check("busy_on", 64'(get_busy(which)), 64'd1);
    check("clken_on", 64'(get_clken(which)), 64'd1);
    while (!got && e < 30) begin
      @(posedge clk); #1;
      e++;
      set_in(which, (row + e) % 16, (col + 3 * e) % 64, (fs + e) % 2, poke && e == 2);
      if (e < nch(which))
        check($sformatf("addr_ch%0d", e), get_addr(which), exp_addr(which, e, row, col, fs));
      if (get_done(which)) got = 1;
      else if (get_pix(which) !== prev) partial_ok = 0;
    end
    set_start(which, 1'b0);
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(e), 64'(lat(which)));
    check("pixels", get_pix(which), exp_pix(which, row, col, fs));
    check("no_partial", 64'(partial_ok), 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(get_done(which)), 64'd0);
    check("idle_after", 64'(get_busy(which)), 64'd0);
  endtask

  // Back-to-back loads: start held high, or re-pulsed in each done cycle.
  task automatic b2b(input int which, input bit held, input int nloads);
    int rr[4], cc[4];
    int e = 0, last = 0;
    bit got;
    for (int k = 0; k < 4; k++) begin
      rr[k] = int'($urandom_range(15));
      cc[k] = int'($urandom_range(63));
    end
    @(negedge clk);
    set_in(which, rr[0], cc[0], 0, 1'b1);
    @(posedge clk); #1;
    if (!held) set_start(which, 1'b0);
    for (int k = 0; k < nloads; k++) begin
      got = 0;
      while (!got && e < last + 30) begin
        @(posedge clk); #1;
        e++;
        if (!held) set_start(which, 1'b0);
        if (get_done(which)) got = 1;
      end
      check("b2b_done_seen", 64'(got), 64'd1);
      if (k == 0) check("b2b_first_latency", 64'(e), 64'(lat(which)));
      else        check("b2b_period", 64'(e - last), 64'(lat(which) + 1));
      last = e;
      check("b2b_pixels", get_pix(which), exp_pix(which, rr[k], cc[k], 0));
      if (k < nloads - 1) set_in(which, rr[k+1], cc[k+1], 0, 1'b1);
    end
    set_start(which, 1'b0);
    repeat (lat(which) + 3) @(posedge clk);
    #1 check("b2b_idle_end", 64'(get_busy(which)), 64'd0);
  endtask

  typedef struct {
    int row;
    int col;
    logic [31:0] pix;
  } vec_t;
  vec_t tbl[4];

  initial begin
    bit bad;
    tbl[0] = '{row: 5,  col: 3,  pix: 32'h057C_017C};
    tbl[1] = '{row: 0,  col: 0,  pix: 32'h043F_003F};
    tbl[2] = '{row: 15, col: 63, pix: 32'h07C0_03C0};
    tbl[3] = '{row: 9,  col: 32, pix: 32'h065F_025F};

    #12;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_pix", 64'(pix_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_clken", 64'(clken_a), 64'd0);
    check("rst_ram_reset", 64'(rreset_a), 64'd1);
    check("rst_pix_b", pix_b, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("ram_reset_released", 64'(rreset_a), 64'd0);

    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_a || busy_a || clken_a || done_b || busy_b) bad = 1;
    end
    check("idle_quiet", 64'(bad), 64'd0);

    // known vectors on the default instance
    for (int i = 0; i < 4; i++) begin
      run_load(0, tbl[i].row, tbl[i].col, 0, 1'b0);
      check($sformatf("tbl_pix%0d", i), 64'(pix_a), 64'(tbl[i].pix));
    end

    // wide instance, then randomized loads on both
    run_load(1, 5, 3, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_load(0, int'($urandom_range(15)), int'($urandom_range(63)),
               int'($urandom_range(1)), 1'($urandom_range(1)));
      run_load(1, int'($urandom_range(15)), int'($urandom_range(63)),
               int'($urandom_range(1)), 1'($urandom_range(1)));
    end
    run_load(0, 3, 10, 1, 1'b1);
    run_load(1, 12, 40, 1, 1'b0);

    b2b(0, 1'b1, 3);
    b2b(0, 1'b0, 3);
    b2b(1, 1'b1, 2);

    // reset two cycles into a load
    @(negedge clk);
    set_in(0, 7, 20, 0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_done", 64'(done_a), 64'd0);
    check("mid_rst_pix", 64'(pix_a), 64'd0);
    check("mid_rst_clken", 64'(clken_a), 64'd0);
    check("mid_rst_addr", 64'(addr_a), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_a || busy_a) bad = 1;
    end
    check("post_rst_quiet", 64'(bad), 64'd0);
    run_load(0, 7, 20, 0, 1'b0);
    run_load(1, 2, 9, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/framebuffer_fetch_multi.md
Name: framebuffer_fetch_multi

Overview:
- Parametrised pixel fetcher between the framebuffer RAM and the panel shifter.
- On each pixel-load request, issues one RAM read per scan channel (top/bottom halves, chained panels) for the current row/column.
- Tolerates a configurable RAM read latency.
- Presents all channel pixels together with a one-cycle done strobe.

Parameters:
- PIXEL_WIDTH, 16, bits per pixel word (rgb565 default).
- COLUMN_BITS, 6, column address width.
- ROW_BITS, 4, row address width.
- NUM_CHANNELS, 2, pixels fetched per load; power of 2, >=2.
- RAM_LATENCY, 2, cycles from address presented to data valid; legal 1..4.
- COLUMN_MIRROR, 1, 1 = column field of address inverted (right-to-left panel scan).

Ports:
- clk_in  input  1  single clock, all logic posedge.
- reset_n  input  1  asynchronous, active-low reset.
- column_address  input  COLUMN_BITS  column of pixel to load.
- row_address  input  ROW_BITS  scan row.
- pixel_load_start  input  1  request; sampled only in IDLE.
- busy  output  1  high from accepted start until done.
- pixel_load_done  output  1  one-cycle strobe; pixels_out updated same cycle.
- ram_data_in  input  PIXEL_WIDTH  RAM read data.
- ram_address  output  CH_BITS+ROW_BITS+COLUMN_BITS  {channel, row, column}; CH_BITS = clog2(NUM_CHANNELS).
- ram_clk_enable  output  1  high while reads are outstanding.
- ram_reset  output  1  active-high, equals ~reset_n.
- pixels_out  output  NUM_CHANNELS*PIXEL_WIDTH  channel 0 in LSBs.

Behaviour:
- Reset (async, reset_n low):
  - state IDLE, busy 0, pixel_load_done 0, ram_clk_enable 0.
  - pixels_out 0, staging 0, ram_address 0.
- Reset mid-operation aborts the load immediately: no done, pixels_out cleared.
- FSM states IDLE, ISSUE, DRAIN.
- IDLE:
  - On pixel_load_start=1: latch row/column, channel counter=0, go ISSUE.
  - ram_clk_enable low.
- ISSUE:
  - One address per cycle: ram_address = {ch, row_latched, COLUMN_MIRROR ? ~col_latched : col_latched}.
  - ch increments each cycle.
  - After ch=NUM_CHANNELS-1 issued, go DRAIN.
- Read tracking:
  - Shift register of RAM_LATENCY stages, each {valid, channel}.
  - When the tail is valid, ram_data_in is written into staging slot [channel] at the end of that cycle.
- DRAIN:
  - Wait until the last channel is captured.
  - At that edge: copy staging to pixels_out, assert pixel_load_done for the next cycle, return to IDLE.
- ram_clk_enable = (state!=IDLE).
- busy = (state!=IDLE).
- Timing: start sampled at edge E0. Channel k address is valid during cycle k+1; its data is captured at the end of cycle k+1+RAM_LATENCY.
- Latency: done is high in the cycle after edge E(NUM_CHANNELS+RAM_LATENCY), i.e. start-to-done = NUM_CHANNELS+RAM_LATENCY edges. Default: 4.
- pixel_load_start while busy: ignored, not queued.
- Start high in the done cycle is accepted, giving back-to-back loads.
- pixels_out holds its value between dones; it never shows partial updates.
- Latched row/column are immune to input changes while busy.
- Elaboration error for illegal NUM_CHANNELS or RAM_LATENCY.

Optional Feature:
- Macro FRAMEBUFFER_FETCH_FRAME_SELECT_EN.
- Defined:
  - Adds input frame_select (1 bit), latched on accepted start.
  - ram_address gains one MSB = latched frame_select, giving double-buffered frames with tear-free swap at load granularity.
- Undefined:
  - No port.
  - Address width as listed.

Decomposition:
- Package framebuffer_fetch_pkg:
  - FSM state enum (IDLE/ISSUE/DRAIN).
  - clog2-derived CH_BITS.
  - RAM_LATENCY bounds constants.
- One sub-module, ram_read_pipe: parametrised valid/channel delay line of RAM_LATENCY stages, outputs capture strobe and channel index.

Test Plan:
- Reset then idle: pixels_out=0, busy=0, done never asserts, ram_clk_enable=0.
- Defaults, row=5, column=3, RAM model returns address as data:
  - ram_address = 0x17C then 0x57C.
  - done exactly 4 edges after start.
  - pixels_out = {0x057C, 0x017C}.
- Back-to-back loads:
  - Start held high continuously: done every 5 cycles.
  - Start pulsed at done: accepted, second load's pixels correct.
  - Start during busy: ignored.
- NUM_CHANNELS=4, RAM_LATENCY=3, COLUMN_MIRROR=0:
  - Four addresses with channel field 0..3.
  - done after 7 edges.
  - All four slots correct.
- reset_n pulsed low 2 cycles after start:
  - busy/done/pixels_out return to 0 immediately.
  - Next load completes normally.
- Feature enabled, frame_select=1 at start, toggled while busy: every issued address has MSB=1.
